// File: rtl/accel_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : accel_sample_sequencer
// Description : Periodic ADXL362 Z-axis reader. A sample tick opens a
//               chip-select window, runs a 4-byte read burst (0x0B, 0x12,
//               dummy, dummy) on a byte-level SPI master, assembles the
//               16-bit sample and strobes it out. Tracks warm-up, per-byte
//               timeouts and tick overruns.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_sample_sequencer #(
  parameter int SAMPLE_DIV     = 1000000,
  parameter int CS_GUARD       = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int WARMUP_SAMPLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        err_clear,
  output logic        cs_n,
  output logic        byte_start,
  output logic [7:0]  byte_tx,
  input  logic        byte_done,
  input  logic [7:0]  byte_rx,
  output logic [15:0] z_data,
  output logic        z_valid,
  output logic        warmup_done,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun_err
);

  localparam int c_DIV_W   = $clog2(SAMPLE_DIV);
  localparam int c_CNT_MAX = (CS_GUARD > TIMEOUT_CYCLES) ? CS_GUARD : TIMEOUT_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_WARM_W  = $clog2(WARMUP_SAMPLES + 1);

  localparam logic [c_DIV_W-1:0]  c_div_last     = c_DIV_W'(SAMPLE_DIV - 1);
  localparam logic [c_CNT_W-1:0]  c_guard_last   = c_CNT_W'(CS_GUARD - 1);
  localparam logic [c_CNT_W-1:0]  c_timeout_last = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_cnt_sat      = c_CNT_W'(c_CNT_MAX);
  localparam logic [c_WARM_W-1:0] c_warm_full    = c_WARM_W'(WARMUP_SAMPLES);
  localparam logic [c_WARM_W-1:0] c_warm_last    = c_WARM_W'(WARMUP_SAMPLES - 1);

  // ADXL362 read burst: READ command, ZDATA_L address, two dummy bytes
  localparam logic [7:0] c_cmd_read   = 8'h0B;
  localparam logic [7:0] c_addr_zdata = 8'h12;
  localparam logic [7:0] c_dummy      = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GUARD_PRE  = 3'd1,
    ST_CMD        = 3'd2,
    ST_ADDR       = 3'd3,
    ST_RD_L       = 3'd4,
    ST_RD_H       = 3'd5,
    ST_GUARD_POST = 3'd6,
    ST_PUBLISH    = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_DIV_W-1:0]   r_div;
  logic                 w_tick;
  logic [c_CNT_W-1:0]   r_state_cnt;
  logic                 w_byte_state;
  logic                 w_byte_ok;
  logic                 w_byte_timeout;
  logic                 w_guard_end;
  logic                 w_overrun_evt;

  logic                 r_cs_n;
  logic                 r_byte_start;
  logic [7:0]           r_byte_tx;
  logic                 r_z_valid;
  logic                 r_busy;
  logic                 w_cs_n_nxt;
  logic                 w_byte_start_nxt;
  logic [7:0]           w_byte_tx_nxt;
  logic                 w_z_valid_nxt;
  logic                 w_busy_nxt;

  logic [7:0]           r_rx_low;
  logic [7:0]           r_rx_high;
  logic [15:0]          r_z_data;
  logic [c_WARM_W-1:0]  r_sample_cnt;
  logic                 r_warmup_done;
  logic                 r_timeout_err;
  logic                 r_overrun_err;

  // Sample-rate divider: runs while enabled, parked at zero otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (!enable || (r_div == c_div_last)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_DIV_W'(1);
    end
  end

  assign w_tick = enable && (r_div == c_div_last);

  // A byte is accepted only after its start cycle, so a done pulse that
  // lines up with byte_start is treated as stale and ignored
  assign w_byte_state   = (r_state inside {ST_CMD, ST_ADDR, ST_RD_L, ST_RD_H});
  assign w_byte_ok      = w_byte_state && byte_done && !r_byte_start;
  assign w_byte_timeout = w_byte_state && !w_byte_ok && (r_state_cnt == c_timeout_last);
  assign w_guard_end    = (r_state_cnt == c_guard_last);
  assign w_overrun_evt  = w_tick && (r_state != ST_IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Cycles spent in the current state; doubles as guard and per-byte timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_state_cnt <= '0;
    end else if (r_state_cnt != c_cnt_sat) begin
      r_state_cnt <= r_state_cnt + c_CNT_W'(1);
    end
  end

  // Next-state logic and next values of the registered outputs
  always_comb begin
    w_next_state     = r_state;
    w_cs_n_nxt       = 1'b1;
    w_byte_start_nxt = 1'b0;
    w_byte_tx_nxt    = r_byte_tx;
    w_z_valid_nxt    = 1'b0;
    w_busy_nxt       = 1'b0;

    unique case (r_state)
      ST_IDLE:       if (w_tick)      w_next_state = ST_GUARD_PRE;
      ST_GUARD_PRE:  if (w_guard_end) w_next_state = ST_CMD;
      ST_CMD:        if (w_byte_ok)   w_next_state = ST_ADDR;
      ST_ADDR:       if (w_byte_ok)   w_next_state = ST_RD_L;
      ST_RD_L:       if (w_byte_ok)   w_next_state = ST_RD_H;
      ST_RD_H:       if (w_byte_ok)   w_next_state = ST_GUARD_POST;
      ST_GUARD_POST: if (w_guard_end) w_next_state = ST_PUBLISH;
      ST_PUBLISH:                     w_next_state = ST_IDLE;
      default:                        w_next_state = ST_IDLE;
    endcase

    // A stalled byte abandons the burst and releases chip select
    if (w_byte_timeout) begin
      w_next_state = ST_IDLE;
    end

    w_cs_n_nxt    = !(w_next_state inside {ST_GUARD_PRE, ST_CMD, ST_ADDR,
                                           ST_RD_L, ST_RD_H, ST_GUARD_POST});
    w_busy_nxt    = (w_next_state != ST_IDLE);
    w_z_valid_nxt = (w_next_state == ST_PUBLISH);

    if ((w_next_state inside {ST_CMD, ST_ADDR, ST_RD_L, ST_RD_H}) &&
        (w_next_state != r_state)) begin
      w_byte_start_nxt = 1'b1;
    end

    unique case (w_next_state)
      ST_CMD:           w_byte_tx_nxt = c_cmd_read;
      ST_ADDR:          w_byte_tx_nxt = c_addr_zdata;
      ST_RD_L, ST_RD_H: w_byte_tx_nxt = c_dummy;
      default:          w_byte_tx_nxt = r_byte_tx;
    endcase
  end

  // Registered interface outputs, derived from the next state so they are glitch-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_n       <= 1'b1;
      r_byte_start <= 1'b0;
      r_byte_tx    <= 8'h00;
      r_z_valid    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_cs_n       <= w_cs_n_nxt;
      r_byte_start <= w_byte_start_nxt;
      r_byte_tx    <= w_byte_tx_nxt;
      r_z_valid    <= w_z_valid_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Receive holding registers and sample assembly; z_data changes only as the strobe opens
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_low  <= 8'h00;
      r_rx_high <= 8'h00;
      r_z_data  <= 16'h0000;
    end else begin
      if ((r_state == ST_RD_L) && w_byte_ok) begin
        r_rx_low <= byte_rx;
      end
      if ((r_state == ST_RD_H) && w_byte_ok) begin
        r_rx_high <= byte_rx;
      end
      if ((w_next_state == ST_PUBLISH) && (r_state != ST_PUBLISH)) begin
        r_z_data <= {r_rx_high, r_rx_low};
      end
    end
  end

  // Warm-up tracking: saturating count of published samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample_cnt  <= '0;
      r_warmup_done <= 1'b0;
    end else if (r_state == ST_PUBLISH) begin
      if (r_sample_cnt != c_warm_full) begin
        r_sample_cnt <= r_sample_cnt + c_WARM_W'(1);
      end
      if (r_sample_cnt >= c_warm_last) begin
        r_warmup_done <= 1'b1;
      end
    end
  end

  // Sticky error flags; a new error event wins over err_clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_byte_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (err_clear) begin
        r_timeout_err <= 1'b0;
      end
      if (w_overrun_evt) begin
        r_overrun_err <= 1'b1;
      end else if (err_clear) begin
        r_overrun_err <= 1'b0;
      end
    end
  end

  assign cs_n        = r_cs_n;
  assign byte_start  = r_byte_start;
  assign byte_tx     = r_byte_tx;
  assign z_data      = r_z_data;
  assign z_valid     = r_z_valid;
  assign warmup_done = r_warmup_done;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign overrun_err = r_overrun_err;

endmodule
`default_nettype wire

// File: tb/tb_accel_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_sample_sequencer
// Description : Self-checking bench for accel_sample_sequencer with a
//               behavioural SPI byte responder and a sample-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_sample_sequencer;

  localparam int SAMPLE_DIV     = 100;
  localparam int CS_GUARD       = 2;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int WARMUP_SAMPLES = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        err_clear;
  logic        cs_n;
  logic        byte_start;
  logic [7:0]  byte_tx;
  logic        byte_done;
  logic [7:0]  byte_rx;
  logic [15:0] z_data;
  logic        z_valid;
  logic        warmup_done;
  logic        busy;
  logic        timeout_err;
  logic        overrun_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_strobes = 0;

  // SPI responder controls and observations
  int         spi_delay     = 1;
  bit         withhold_rd_l = 1'b0;
  logic [7:0] spi_lo        = 8'h00;
  logic [7:0] spi_hi        = 8'h00;
  int         idx           = 0;
  int         rd_l_start_cyc = 0;
  bit         rd_h_started  = 1'b0;
  logic [7:0] tx0;
  int         d_now;

  // Sample-level model state
  int          published = 0;
  logic [15:0] last_z    = 16'h0000;
  int          last_fall = 0;
  logic        prev_zv   = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  accel_sample_sequencer #(
    .SAMPLE_DIV     (SAMPLE_DIV),
    .CS_GUARD       (CS_GUARD),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .WARMUP_SAMPLES (WARMUP_SAMPLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .err_clear   (err_clear),
    .cs_n        (cs_n),
    .byte_start  (byte_start),
    .byte_tx     (byte_tx),
    .byte_done   (byte_done),
    .byte_rx     (byte_rx),
    .z_data      (z_data),
    .z_valid     (z_valid),
    .warmup_done (warmup_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Command byte expected at each position of the ADXL362 read burst
  function automatic logic [7:0] exp_tx(input int pos);
    if (pos == 0) return 8'h0B;
    if (pos == 1) return 8'h12;
    return 8'h00;
  endfunction

  task automatic check_reset_values();
    check("rst_cs_n",        cs_n,        1);
    check("rst_byte_start",  byte_start,  0);
    check("rst_byte_tx",     byte_tx,     0);
    check("rst_z_data",      z_data,      0);
    check("rst_z_valid",     z_valid,     0);
    check("rst_warmup_done", warmup_done, 0);
    check("rst_busy",        busy,        0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_overrun_err", overrun_err, 0);
  endtask

  task automatic start_sample(input logic [7:0] lo, input logic [7:0] hi,
                              input int d, input int gap);
    int n;
    spi_lo = lo;
    spi_hi = hi;
    spi_delay = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cs_n !== 1'b0 && n < 3 * SAMPLE_DIV);
    check("cs_n_fall", cs_n, 0);
    check("tick_period", cyc - last_fall, gap);
    last_fall = cyc;
    check("busy_in_burst", busy, 1);
    check("z_data_hold", z_data, last_z);
  endtask

  task automatic finish_sample(input logic [7:0] lo, input logic [7:0] hi, input int d);
    int len;
    len = 1;
    while (cs_n === 1'b0 && len < 4000) begin
      @(negedge clk);
      if (cs_n === 1'b0) len++;
    end
    check("cs_low_len", len, 2 * CS_GUARD + 4 * (d + 1));
    check("z_valid", z_valid, 1);
    check("z_data", z_data, {hi, lo});
    check("busy_at_strobe", busy, 1);
    check("warmup_at_strobe", warmup_done, published >= WARMUP_SAMPLES);
    published++;
    last_z = {hi, lo};
    @(negedge clk);
    check("z_valid_single", z_valid, 0);
    check("busy_after", busy, 0);
    check("warmup_after", warmup_done, published >= WARMUP_SAMPLES);
    check("z_data_after", z_data, last_z);
  endtask

  task automatic run_sample(input logic [7:0] lo, input logic [7:0] hi,
                            input int d, input int gap);
    start_sample(lo, hi, d, gap);
    finish_sample(lo, hi, d);
  endtask

  // SPI master model: answers each byte_start after spi_delay cycles
  initial begin
    byte_done = 1'b0;
    byte_rx   = 8'h00;
    @(negedge clk);
    forever begin
      if (cs_n !== 1'b0) idx = 0;
      if (byte_start === 1'b1) begin
        tx0 = byte_tx;
        check("byte_tx", tx0, exp_tx(idx));
        check("cs_n_at_start", cs_n, 0);
        if (idx == 2) rd_l_start_cyc = cyc;
        if (idx == 3) rd_h_started = 1'b1;
        if (withhold_rd_l && idx == 2) begin
          @(negedge clk);
        end else begin
          d_now = spi_delay;
          repeat (d_now) @(negedge clk);
          check("byte_tx_held", byte_tx, tx0);
          byte_rx   = (idx == 2) ? spi_lo : (idx == 3) ? spi_hi : 8'($urandom);
          byte_done = 1'b1;
          @(negedge clk);
          byte_done = 1'b0;
          byte_rx   = 8'($urandom);
        end
        idx++;
      end else begin
        @(negedge clk);
      end
    end
  end

  // Strobe monitor: every strobe is single-cycle, inside busy, with cs_n released
  always @(negedge clk) begin
    if (z_valid === 1'b1) begin
      n_strobes++;
      check("z_valid_b2b", prev_zv, 0);
      check("cs_n_at_strobe", cs_n, 1);
    end
    prev_zv = z_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int n0;
    logic [7:0] lo;
    logic [7:0] hi;
    int d;

    reset = 1'b1;
    enable = 1'b0;
    err_clear = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;

    // Disabled: divider parked, no activity
    n = 0;
    repeat (2 * SAMPLE_DIV) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || busy !== 1'b0) n++;
    end
    check("idle_while_disabled", n, 0);

    enable = 1'b1;
    last_fall = cyc;
    run_sample(8'h34, 8'h12, 1, SAMPLE_DIV);
    run_sample(8'h9C, 8'hFF, 1, SAMPLE_DIV);
    check("z_signed_neg", int'($signed(z_data)), -100);
    run_sample(8'h00, 8'h00, 1, SAMPLE_DIV);
    for (int i = 0; i < 8; i++) begin
      lo = 8'($urandom);
      hi = 8'($urandom);
      d  = $urandom_range(8, 1);
      run_sample(lo, hi, d, SAMPLE_DIV);
    end
    check("warmup_held", warmup_done, 1);
    check("no_overrun_normal", overrun_err, 0);

    // Timeout: RD_L never completes
    n0 = n_strobes;
    withhold_rd_l = 1'b1;
    start_sample(8'h55, 8'hAA, 1, SAMPLE_DIV);
    n = 0;
    while (timeout_err !== 1'b1 && n < 4 * TIMEOUT_CYCLES) begin
      @(negedge clk);
      n++;
    end
    check("timeout_err_set", timeout_err, 1);
    check("timeout_latency", cyc - rd_l_start_cyc, TIMEOUT_CYCLES);
    check("timeout_cs_n", cs_n, 1);
    check("timeout_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("timeout_no_strobe", n_strobes - n0, 0);
    withhold_rd_l = 1'b0;
    run_sample(8'h21, 8'h43, 2, SAMPLE_DIV);
    check("timeout_sticky", timeout_err, 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("timeout_cleared", timeout_err, 0);
    check("overrun_still_clear", overrun_err, 0);

    // Enable dropped mid-burst: burst completes, no further ticks
    lo = 8'($urandom);
    hi = 8'($urandom);
    start_sample(lo, hi, 1, SAMPLE_DIV);
    enable = 1'b0;
    finish_sample(lo, hi, 1);
    n = 0;
    repeat (3 * SAMPLE_DIV) begin
      @(negedge clk);
      if (cs_n !== 1'b1) n++;
    end
    check("no_tick_after_disable", n, 0);

    // Overrun: slow SPI makes the burst longer than the tick period
    enable = 1'b1;
    last_fall = cyc;
    n0 = n_strobes;
    lo = 8'($urandom);
    hi = 8'($urandom);
    run_sample(lo, hi, 30, SAMPLE_DIV);
    check("overrun_set", overrun_err, 1);
    check("overrun_one_strobe", n_strobes - n0, 1);
    lo = 8'($urandom);
    hi = 8'($urandom);
    run_sample(lo, hi, 30, 2 * SAMPLE_DIV);
    check("overrun_two_strobes", n_strobes - n0, 2);
    check("overrun_no_timeout", timeout_err, 0);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("overrun_cleared", overrun_err, 0);

    // Reset in the middle of RD_H
    rd_h_started = 1'b0;
    start_sample(8'h77, 8'h66, 8, 2 * SAMPLE_DIV);
    n = 0;
    while (!rd_h_started && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_rd_h", rd_h_started, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    published = 0;
    last_z = 16'h0000;
    last_fall = cyc;
    lo = 8'($urandom);
    hi = 8'($urandom);
    run_sample(lo, hi, 1, SAMPLE_DIV);
    check("warmup_restarted", warmup_done, 0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accel_sample_sequencer.md
Name: accel_sample_sequencer

Overview:
- Schedules periodic Z-axis reads from the ADXL362 accelerometer over a byte-level SPI master.
- Each read is a 4-byte burst; the sequencer assembles the 16-bit sample and issues a single-cycle z_data/z_valid strobe to the accel preprocessing stage.
- Tracks filter warm-up, SPI timeouts and sample-tick overruns so downstream motion logic ignores samples until the baseline has settled.

Parameters:
- SAMPLE_DIV, 1000000, clk cycles per sample tick (100 Hz at 100 MHz); must be ≥ 16.
- CS_GUARD, 8, clk cycles cs_n is held low before the first byte and after the last byte.
- TIMEOUT_CYCLES, 4096, maximum clk cycles to wait for byte_done per byte.
- WARMUP_SAMPLES, 64, number of published samples before warmup_done asserts; must be ≥ 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  level; allows new sample transactions
- err_clear  in  1  pulse; clears timeout_err and overrun_err
- cs_n  out  1  ADXL362 chip select, active-low
- byte_start  out  1  one-cycle pulse requesting a byte transfer from the SPI master
- byte_tx  out  8  byte to shift out; held stable from byte_start until byte_done
- byte_done  in  1  one-cycle pulse from the SPI master when the byte transfer completes
- byte_rx  in  8  received byte; valid in the byte_done cycle
- z_data  out  16  signed sample {ZDATA_H, ZDATA_L}
- z_valid  out  1  one-cycle strobe, z_data valid
- warmup_done  out  1  level; high once WARMUP_SAMPLES samples are published
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky
- overrun_err  out  1  sticky

Behaviour:
- Reset values: cs_n=1, byte_start=0, byte_tx=0, z_data=0, z_valid=0, warmup_done=0, busy=0, timeout_err=0, overrun_err=0. FSM=IDLE, divider=0, sample counter=0.
- Divider:
  - Counts 0..SAMPLE_DIV-1 while enable=1; tick is asserted for one cycle when the count wraps to 0.
  - With enable=0 the divider holds at 0 and no ticks are generated.
- FSM states and transitions:
  - IDLE: on tick, go to GUARD_PRE and drive cs_n=0.
  - GUARD_PRE: wait CS_GUARD cycles, then go to CMD.
  - CMD: pulse byte_start with byte_tx=0x0B; wait for byte_done, then go to ADDR.
  - ADDR: byte_tx=0x12; wait for byte_done, then go to RD_L.
  - RD_L: byte_tx=0x00; on byte_done latch byte_rx into the low holding register, then go to RD_H.
  - RD_H: byte_tx=0x00; on byte_done latch the high byte, then go to GUARD_POST.
  - GUARD_POST: cs_n stays 0 for CS_GUARD cycles, then set cs_n=1 and go to PUBLISH.
  - PUBLISH: one cycle. z_data <= {high, low}; z_valid=1; sample counter increments, saturating at WARMUP_SAMPLES; go to IDLE.
- byte_start rules:
  - Pulses exactly once, in the first cycle of each byte state.
  - A byte_done arriving in the same cycle as byte_start is ignored.
  - byte_done pulses outside CMD/ADDR/RD_L/RD_H are ignored.
- Latency: the tick-to-z_valid delay is 2·CS_GUARD + 4 byte times + fixed FSM cycles. Latency is deterministic for a fixed-rate SPI master.
- z_data holds its value between strobes and is never updated without z_valid.
- warmup_done: registered; rises in the cycle after the PUBLISH that brings the counter to WARMUP_SAMPLES; stays high until reset.
- Timeout:
  - A per-byte counter restarts at each byte_start.
  - If TIMEOUT_CYCLES elapse without byte_done: cs_n=1, timeout_err=1, return to IDLE with no z_valid and no counter change.
- Overrun:
  - A tick while the FSM is not IDLE sets overrun_err; that tick is dropped, never queued.
- err_clear:
  - Clears both sticky flags.
  - If err_clear coincides with a new error event, the set wins.
- enable deasserted mid-transaction: the current transaction completes and publishes; no new tick follows.
- z_valid and busy: z_valid is generated in PUBLISH, so busy=1 in the z_valid cycle and drops the following cycle.

Test Plan:
- SAMPLE_DIV=100, CS_GUARD=2, SPI model returns 0x34 then 0x12 -> byte_tx sequence 0x0B,0x12,0x00,0x00; one z_valid with z_data=0x1234; cs_n low for the entire burst only.
- Negative sample: rx 0x9C, 0xFF -> z_data=0xFF9C (−100); next tick with rx 0x00, 0x00 -> z_data=0x0000.
- WARMUP_SAMPLES=4 -> warmup_done low after 3 strobes and high the cycle after the 4th; still high after 10 strobes.
- SPI model withholds byte_done in RD_L, TIMEOUT_CYCLES=50 -> after 50 cycles cs_n=1, timeout_err=1, no z_valid; next tick completes normally; err_clear -> timeout_err=0.
- SAMPLE_DIV=16 with a slow SPI model (byte time 20 cycles) -> overrun_err=1 and one z_valid per completed transaction, never two back-to-back.
- Reset asserted during RD_H -> all outputs return to reset values immediately, including cs_n=1; after release the first sample arrives only after a full SAMPLE_DIV period.
